fifo_lvl: RTL and testbench

Parametrised first-word-fall-through FIFO. It is the next-generation replacement for the fixed 2-stage FIFO used between the io881 bus interface and the channel engines. It adds:
- arbitrary depth, including non-power-of-2 depths;
- a fill-level output and programmable almost-full/almost-empty thresholds;
- sticky overflow/underflow error flags and a synchronous flush;
- an optional empty-bypass passthrough path.

---
 rtl/fifo_lvl_pkg.sv | 40 ++++
 rtl/fifo_ptr.sv | 51 +++++
 rtl/fifo_lvl.sv | 168 ++++++++++++++++
 tb/tb_fifo_lvl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_lvl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_lvl_pkg
//  Purpose  : Shared sizing helpers, default thresholds and level-encoding
//             constants for fifo_lvl, its pointer sub-module and benches.
//  Contents : lvl_width()    - width of the level counter, $clog2(DEPTH+1)
//             ptr_width()    - width of a modulo-DEPTH pointer
//             def_af_level() - default almost-full threshold (DEPTH-1)
//             DEF_AE_LEVEL   - default almost-empty threshold
//             LVL_EMPTY      - level value meaning "no entries"
//             lvl_op_e       - per-edge level counter action
//  Revision : 1.0 - initial release
// ============================================================================
package fifo_lvl_pkg;

  // The level must be able to represent DEPTH itself, hence DEPTH+1 codes.
  function automatic int unsigned lvl_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  // Pointers only address 0..DEPTH-1; keep at least one bit.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

  function automatic int unsigned def_af_level(input int unsigned depth);
    return depth - 1;
  endfunction

  localparam int unsigned DEF_AE_LEVEL = 1;
  localparam int unsigned LVL_EMPTY    = 0;

  typedef enum logic [1:0] {
    LVL_OP_HOLD = 2'd0,
    LVL_OP_INC  = 2'd1,
    LVL_OP_DEC  = 2'd2
  } lvl_op_e;

endpackage : fifo_lvl_pkg
`default_nettype wire

// File: rtl/fifo_ptr.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_ptr
//  Purpose  : Modulo-DEPTH pointer with increment enable. Wraps explicitly
//             from DEPTH-1 to 0, so any DEPTH (power of 2 or not) works.
//  Ports    : clk   - clock, rising edge
//             rst_n - asynchronous active-low reset (pointer -> 0)
//             clr   - synchronous clear (pointer -> 0), wins over inc
//             inc   - advance pointer by one at the next edge
//             ptr   - current pointer value
//  Revision : 1.0 - initial release
// ============================================================================
module fifo_ptr
  import fifo_lvl_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned PW    = ptr_width(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          inc,
  output logic [PW-1:0] ptr
);

  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (clr) begin
      ptr_d = '0;
    end else if (inc) begin
      ptr_d = (ptr_q == PTR_LAST) ? '0 : ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule : fifo_ptr
`default_nettype wire

// File: rtl/fifo_lvl.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_lvl
//  Purpose  : Parametrised first-word-fall-through FIFO with fill level,
//             almost-full/almost-empty thresholds, sticky overflow/underflow
//             flags, synchronous flush and optional empty-FIFO bypass.
//  Ports    : clk, rst_n            - clock / async active-low reset
//             flush                 - synchronous clear, highest priority
//             d_in, d_in_strobe     - write data / write request
//             q, q_ready            - head data / head valid
//             q_out_strobe          - read (consume) request
//             empty, full, level    - occupancy status (registered state)
//             almost_full/_empty    - threshold compares on level
//             overflow, underflow   - sticky error flags
//  Revision : 1.0 - initial release
// ============================================================================
module fifo_lvl
  import fifo_lvl_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned DEPTH    = 2,
  parameter int unsigned AF_LEVEL = def_af_level(DEPTH),
  parameter int unsigned AE_LEVEL = DEF_AE_LEVEL,
  parameter int unsigned BYPASS   = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic [WIDTH-1:0]             d_in,
  input  logic                         d_in_strobe,
  output logic [WIDTH-1:0]             q,
  output logic                         q_ready,
  input  logic                         q_out_strobe,
  output logic                         empty,
  output logic                         full,
  output logic [lvl_width(DEPTH)-1:0]  level,
  output logic                         almost_full,
  output logic                         almost_empty,
  output logic                         overflow,
  output logic                         underflow
);

  localparam int unsigned   LW        = lvl_width(DEPTH);
  localparam int unsigned   PW        = ptr_width(DEPTH);
  localparam logic [LW-1:0] LVL_ZERO  = LW'(LVL_EMPTY);
  localparam logic [LW-1:0] LVL_FULL  = LW'(DEPTH);
  localparam logic [LW-1:0] LVL_AF    = LW'(AF_LEVEL);
  localparam logic [LW-1:0] LVL_AE    = LW'(AE_LEVEL);
  localparam bit            BYPASS_ON = (BYPASS != 0);

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [LW-1:0] level_q, level_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;

  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;

  logic    has_data;
  logic    bypass_en;
  logic    rd_acc;
  logic    wr_acc;
  logic    rd_mem;
  logic    wr_mem;
  lvl_op_e lvl_op;

  // Head presentation and accept decisions.
  always_comb begin
    has_data  = (level_q != LVL_ZERO);
    bypass_en = BYPASS_ON && d_in_strobe && !has_data;
    q_ready   = has_data || bypass_en;

    q = '0;
    if (has_data) begin
      q = mem_q[rd_ptr];
    end else if (bypass_en) begin
      q = d_in;
    end

    rd_acc = !flush && q_out_strobe && q_ready;
    // A read accepted in the same edge frees a slot even when full.
    wr_acc = !flush && d_in_strobe && ((level_q != LVL_FULL) || rd_acc);

    // A read with no stored data can only be the bypass passthrough: the
    // incoming word is consumed directly and never touches storage.
    rd_mem = rd_acc && has_data;
    wr_mem = wr_acc && !(rd_acc && !has_data);

    lvl_op = LVL_OP_HOLD;
    if (wr_mem && !rd_mem) begin
      lvl_op = LVL_OP_INC;
    end else if (rd_mem && !wr_mem) begin
      lvl_op = LVL_OP_DEC;
    end
  end

  // Level counter and sticky flags.
  always_comb begin
    level_d     = level_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (flush) begin
      level_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      case (lvl_op)
        LVL_OP_INC: level_d = level_q + LW'(1);
        LVL_OP_DEC: level_d = level_q - LW'(1);
        default:    level_d = level_q;
      endcase
      overflow_d  = overflow_q  || (d_in_strobe  && !wr_acc);
      underflow_d = underflow_q || (q_out_strobe && !rd_acc);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      level_q     <= level_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is intentionally not reset; level/pointers define validity.
  always_ff @(posedge clk) begin
    if (wr_mem) begin
      mem_q[wr_ptr] <= d_in;
    end
  end

  fifo_ptr #(
    .DEPTH (DEPTH),
    .PW    (PW)
  ) u_rd_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (flush),
    .inc   (rd_mem),
    .ptr   (rd_ptr)
  );

  fifo_ptr #(
    .DEPTH (DEPTH),
    .PW    (PW)
  ) u_wr_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (flush),
    .inc   (wr_mem),
    .ptr   (wr_ptr)
  );

  assign level        = level_q;
  assign empty        = (level_q == LVL_ZERO);
  assign full         = (level_q == LVL_FULL);
  assign almost_full  = (level_q >= LVL_AF);
  assign almost_empty = (level_q <= LVL_AE);
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule : fifo_lvl
`default_nettype wire

// File: tb/tb_fifo_lvl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fifo_lvl
//  Purpose  : Self-checking bench for fifo_lvl. Main instance: DEPTH=5,
//             AF_LEVEL=4, AE_LEVEL=1, BYPASS=1, driven by directed and random
//             traffic against a queue-based reference model with a decoupled
//             monitor. Second instance: DEPTH=2, BYPASS=0, directed checks.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_lvl;

  localparam int D  = 5;
  localparam int AF = 4;
  localparam int AE = 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  // Main instance signals
  logic       flush = 1'b0;
  logic [7:0] d_in = '0;
  logic       d_in_strobe = 1'b0;
  logic       q_out_strobe = 1'b0;
  logic [7:0] q;
  logic       q_ready, empty, full, almost_full, almost_empty, overflow, underflow;
  logic [2:0] level;

  // No-bypass instance signals
  logic       flush2 = 1'b0;
  logic [7:0] d_in2 = '0;
  logic       wr2 = 1'b0;
  logic       rd2 = 1'b0;
  logic [7:0] q2;
  logic       q_ready2, empty2, full2, af2, ae2, ovf2, udf2;
  logic [1:0] level2;

  always #5 clk = ~clk;

  fifo_lvl #(
    .WIDTH(8), .DEPTH(D), .AF_LEVEL(AF), .AE_LEVEL(AE), .BYPASS(1)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .d_in(d_in),
    .d_in_strobe(d_in_strobe), .q(q), .q_ready(q_ready),
    .q_out_strobe(q_out_strobe), .empty(empty), .full(full), .level(level),
    .almost_full(almost_full), .almost_empty(almost_empty),
    .overflow(overflow), .underflow(underflow)
  );

  fifo_lvl #(
    .WIDTH(8), .DEPTH(2), .AF_LEVEL(1), .AE_LEVEL(1), .BYPASS(0)
  ) u_dut_nb (
    .clk(clk), .rst_n(rst_n), .flush(flush2), .d_in(d_in2),
    .d_in_strobe(wr2), .q(q2), .q_ready(q_ready2),
    .q_out_strobe(rd2), .empty(empty2), .full(full2), .level(level2),
    .almost_full(af2), .almost_empty(ae2),
    .overflow(ovf2), .underflow(udf2)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model and scoreboard ----------------
  typedef struct {
    int lvl;
    bit emp, ful, af, ae, ovf, udf, rdy;
  } stat_t;

  stat_t      st_q[$];
  logic [7:0] dat_q[$];
  logic [7:0] m_fifo[$];
  bit         m_ovf = 1'b0;
  bit         m_udf = 1'b0;
  bit         mon_en = 1'b0;
  stat_t      mon_s;

  // Issue one cycle of stimulus; record what the DUT must show during this
  // cycle, then apply the FIFO rules to the model for the coming edge.
  task automatic step(input bit wr, input bit rd, input bit fl, input logic [7:0] din);
    stat_t s;
    int    n;
    bit    avail, rd_ok, wr_ok, pass;
    d_in = din; d_in_strobe = wr; q_out_strobe = rd; flush = fl;
    n = m_fifo.size();
    s.lvl = n; s.emp = (n == 0); s.ful = (n == D);
    s.af = (n >= AF); s.ae = (n <= AE);
    s.ovf = m_ovf; s.udf = m_udf; s.rdy = (n > 0) || wr;
    st_q.push_back(s);
    if (fl) begin
      m_fifo.delete(); m_ovf = 1'b0; m_udf = 1'b0;
    end else begin
      avail = (n > 0) || wr;
      rd_ok = rd && avail;
      if (rd && !avail) m_udf = 1'b1;
      wr_ok = wr && ((n < D) || rd_ok);
      if (wr && !wr_ok) m_ovf = 1'b1;
      pass = 1'b0;
      if (rd_ok) begin
        if (n > 0) dat_q.push_back(m_fifo.pop_front());
        else begin dat_q.push_back(din); pass = 1'b1; end
      end
      if (wr_ok && !pass) m_fifo.push_back(din);
    end
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (st_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL status_queue: got empty expected an entry at %0t", $time);
      end else begin
        mon_s = st_q.pop_front();
        chk("level", level, mon_s.lvl);
        chk("empty", empty, mon_s.emp);
        chk("full", full, mon_s.ful);
        chk("almost_full", almost_full, mon_s.af);
        chk("almost_empty", almost_empty, mon_s.ae);
        chk("overflow", overflow, mon_s.ovf);
        chk("underflow", underflow, mon_s.udf);
        chk("q_ready", q_ready, mon_s.rdy);
      end
      if (!q_ready) chk("q_idle_zero", q, 0);
      if (q_ready && q_out_strobe && !flush) begin
        if (dat_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL q_data: got 0x%0h expected no read at %0t", q, $time);
        end else begin
          chk("q_data", q, dat_q.pop_front());
        end
      end
    end
  end

  initial begin
    // ---------------- reset values ----------------
    #1;
    chk("rst_empty", empty, 1);  chk("rst_full", full, 0);
    chk("rst_q_ready", q_ready, 0); chk("rst_q", q, 0);
    chk("rst_level", level, 0);  chk("rst_ae", almost_empty, 1);
    chk("rst_af", almost_full, 0);
    chk("rst_ovf", overflow, 0); chk("rst_udf", underflow, 0);
    chk("rst2_empty", empty2, 1); chk("rst2_level", level2, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // ---------------- no-bypass instance, DEPTH=2 ----------------
    wr2 = 1'b1; d_in2 = 8'h55; #1;
    chk("nb_write_not_ready_yet", q_ready2, 0);
    @(posedge clk); #1; wr2 = 1'b0;
    chk("nb_q_after_write", q2, 8'h55); chk("nb_ready_after_write", q_ready2, 1);
    chk("nb_level_after_write", level2, 1); chk("nb_empty_after_write", empty2, 0);
    rd2 = 1'b1;
    @(posedge clk); #1; rd2 = 1'b0;
    chk("nb_empty_after_read", empty2, 1); chk("nb_ready_after_read", q_ready2, 0);
    wr2 = 1'b1; rd2 = 1'b1; d_in2 = 8'hAA; #1;
    chk("nb_no_bypass_ready", q_ready2, 0);
    @(posedge clk); #1; rd2 = 1'b0;
    chk("nb_underflow", udf2, 1); chk("nb_level_stored", level2, 1);
    chk("nb_q_stored", q2, 8'hAA); chk("nb_no_overflow", ovf2, 0);
    d_in2 = 8'hBB;
    @(posedge clk); #1;
    chk("nb_full", full2, 1); chk("nb_level_full", level2, 2);
    @(posedge clk); #1; wr2 = 1'b0;
    chk("nb_overflow", ovf2, 1); chk("nb_level_held", level2, 2);
    chk("nb_head_kept", q2, 8'hAA);
    flush2 = 1'b1;
    @(posedge clk); #1; flush2 = 1'b0;
    chk("nb_flush_level", level2, 0); chk("nb_flush_ovf", ovf2, 0);
    chk("nb_flush_udf", udf2, 0);

    // ---------------- main instance, scoreboard driven ----------------
    mon_en = 1'b1;
    // write then read, bypass passthrough
    step(1, 0, 0, 8'h55);
    step(0, 1, 0, 8'h00);
    step(1, 1, 0, 8'hAA);
    step(0, 0, 0, 8'h00);
    // fill to full, overflow, drain across the wrap
    for (int i = 1; i <= 6; i++) step(1, 0, 0, 8'(i));
    for (int i = 0; i < 5; i++) step(0, 1, 0, 8'h00);
    step(1, 0, 0, 8'h10);
    for (int i = 0; i < 7; i++) step(1, 1, 0, 8'(8'h11 + i));
    step(0, 1, 0, 8'h00);
    // full with simultaneous write+read, then drain
    for (int i = 0; i < 5; i++) step(1, 0, 0, 8'(8'h20 + i));
    for (int i = 0; i < 3; i++) step(1, 1, 0, 8'(8'h30 + i));
    for (int i = 0; i < 6; i++) step(0, 1, 0, 8'h00);
    // flush with a strobed write after setting both flags
    for (int i = 0; i < 3; i++) step(1, 0, 0, 8'(8'h40 + i));
    step(1, 1, 1, 8'h4F);
    step(0, 0, 0, 8'h00);
    step(0, 0, 0, 8'h00);
    // random traffic in three phases of different bias
    for (int ph = 0; ph < 3; ph++) begin
      for (int i = 0; i < 800; i++) begin
        int wp, rp;
        wp = (ph == 0) ? 70 : (ph == 1) ? 30 : 50;
        rp = (ph == 0) ? 30 : (ph == 1) ? 70 : 50;
        step(($urandom_range(0, 99) < wp), ($urandom_range(0, 99) < rp),
             ($urandom_range(0, 63) == 0), 8'($urandom));
      end
    end
    // reset pulsed mid-burst after overflowing
    for (int i = 0; i < 7; i++) step(1, 0, 0, 8'(8'h60 + i));
    mon_en = 1'b0;
    d_in_strobe = 1'b0; q_out_strobe = 1'b0; flush = 1'b0;
    rst_n = 1'b0; #1;
    chk("mid_rst_level", level, 0); chk("mid_rst_empty", empty, 1);
    chk("mid_rst_full", full, 0);   chk("mid_rst_q_ready", q_ready, 0);
    chk("mid_rst_q", q, 0);         chk("mid_rst_ovf", overflow, 0);
    chk("mid_rst_udf", underflow, 0); chk("mid_rst_ae", almost_empty, 1);
    chk("mid_rst_af", almost_full, 0);
    chk("pre_rst_data_drained", dat_q.size(), 0);
    m_fifo.delete(); dat_q.delete(); st_q.delete();
    m_ovf = 1'b0; m_udf = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    mon_en = 1'b1;
    step(0, 1, 0, 8'h00);
    step(1, 0, 0, 8'h77);
    step(0, 1, 0, 8'h00);
    step(0, 0, 0, 8'h00);
    mon_en = 1'b0;
    chk("data_queue_drained", dat_q.size(), 0);
    chk("status_queue_drained", st_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_fifo_lvl
`default_nettype wire
